flash_reader: RTL and testbench



---
 rtl/flash_pkg.sv | 22 ++
 rtl/flash_shift.sv | 92 +++++++++
 rtl/flash_reader.sv | 158 +++++++++++++++
 tb/tb_flash_reader.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Shared types and constants for the SPI flash read path.
package flash_pkg;

  typedef enum logic [2:0] {
    StWakeCmd,
    StWakeWait,
    StIdle,
    StCmd,
    StAddr,
    StData,
    StDone
  } state_e;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_WAKE = 8'hAB;

  // Flash returns bytes in address order; the first byte lands in the low lane.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/flash_shift.sv
// SPI mode-0 bit engine: SCLK generation plus MSB-first MOSI/MISO shift registers.
module flash_shift #(
  parameter int unsigned Div = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [5:0]  len_i,
  input  logic [31:0] data_i,
  input  logic        miso_i,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic [31:0] rx_o,
  output logic        bit_done_o,
  output logic        last_o
);

  localparam int unsigned HalfW = $clog2(Div + 1);
  localparam logic [HalfW-1:0] HalfLast = HalfW'(Div - 1);

  logic              active_q, active_d;
  logic              sclk_q, sclk_d;
  logic [HalfW-1:0]  hcnt_q, hcnt_d;
  logic [5:0]        bit_q, bit_d;
  logic [5:0]        len_q, len_d;
  logic [31:0]       tx_q, tx_d;
  logic [31:0]       rx_q, rx_d;
  logic              half_end;

  assign half_end   = active_q && (hcnt_q == HalfLast);
  assign bit_done_o = half_end && sclk_q;
  assign last_o     = (bit_q == len_q);
  assign sclk_o     = sclk_q;
  assign mosi_o     = tx_q[31];
  assign rx_o       = rx_q;

  always_comb begin
    active_d = active_q;
    sclk_d   = sclk_q;
    hcnt_d   = hcnt_q;
    bit_d    = bit_q;
    len_d    = len_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    if (half_end) begin
      hcnt_d = '0;
      if (!sclk_q) begin
        // Rising SCLK edge: sample MISO.
        sclk_d = 1'b1;
        rx_d   = {rx_q[30:0], miso_i};
      end else begin
        // Falling SCLK edge: present the next MOSI bit.
        sclk_d = 1'b0;
        tx_d   = {tx_q[30:0], 1'b0};
        bit_d  = bit_q + 6'd1;
        if (last_o) active_d = 1'b0;
      end
    end else if (active_q) begin
      hcnt_d = hcnt_q + 1'b1;
    end
    // A load on the final bit_done chains segments with no gap in SCLK.
    if (load_i) begin
      active_d = 1'b1;
      sclk_d   = 1'b0;
      hcnt_d   = '0;
      bit_d    = '0;
      len_d    = len_i;
      tx_d     = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      hcnt_q   <= '0;
      bit_q    <= '0;
      len_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else begin
      active_q <= active_d;
      sclk_q   <= sclk_d;
      hcnt_q   <= hcnt_d;
      bit_q    <= bit_d;
      len_q    <= len_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
    end
  end

endmodule

// File: rtl/flash_reader.sv
// Memory-bus responder: wakes the SPI flash after reset, then serves each 32-bit read
// with a single-I/O READ (0x03) transaction.
module flash_reader
  import flash_pkg::*;
#(
  parameter int unsigned DIV         = 1,
  parameter int unsigned CSN_HIGH    = 4,
  parameter int unsigned WAKE_CYCLES = 48
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic [31:0] address_in,
  output logic        ready_out,
  output logic [31:0] read_value_out,
  output logic        flash_clk,
  output logic        flash_csn,
  output logic        flash_io0_out,
  output logic        flash_io0_en,
  input  logic        flash_io1_in
);

  localparam int unsigned GapW  = $clog2(CSN_HIGH + 1);
  localparam int unsigned WaitW = $clog2(WAKE_CYCLES + 1);
  localparam logic [GapW-1:0]  GapMax   = GapW'(CSN_HIGH);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(WAKE_CYCLES - 1);

  state_e            state_q, state_d;
  logic              csn_q, csn_d;
  logic              ready_q, ready_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [23:0]       addr_q, addr_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [WaitW-1:0]  wait_q, wait_d;

  logic        sh_load;
  logic [5:0]  sh_len;
  logic [31:0] sh_data;
  logic [31:0] sh_rx;
  logic        bit_done;
  logic        last_bit;
  logic        seg_end;
  logic        unused_addr;

  assign unused_addr = ^{address_in[31:24], address_in[1:0]};
  assign seg_end     = bit_done && last_bit;

  flash_shift #(
    .Div(DIV)
  ) u_shift (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .load_i    (sh_load),
    .len_i     (sh_len),
    .data_i    (sh_data),
    .miso_i    (flash_io1_in),
    .sclk_o    (flash_clk),
    .mosi_o    (flash_io0_out),
    .rx_o      (sh_rx),
    .bit_done_o(bit_done),
    .last_o    (last_bit)
  );

  always_comb begin
    state_d = state_q;
    csn_d   = csn_q;
    ready_d = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wait_d  = wait_q;
    // Counts CS-high cycles, saturating at the required gap.
    gap_d   = (csn_q && (gap_q != GapMax)) ? gap_q + 1'b1 : gap_q;
    sh_load = 1'b0;
    sh_len  = '0;
    sh_data = '0;
    case (state_q)
      StWakeCmd: begin
        if (csn_q) begin
          sh_load = 1'b1;
          sh_len  = 6'd7;
          sh_data = {CMD_WAKE, 24'h0};
          csn_d   = 1'b0;
        end else if (seg_end) begin
          csn_d   = 1'b1;
          gap_d   = '0;
          wait_d  = '0;
          state_d = StWakeWait;
        end
      end
      StWakeWait: begin
        if (wait_q == WaitLast) state_d = StIdle;
        else                    wait_d  = wait_q + 1'b1;
      end
      StIdle: begin
        if (valid_in && (gap_q == GapMax)) begin
          addr_d  = {address_in[23:2], 2'b00};
          sh_load = 1'b1;
          sh_len  = 6'd7;
          sh_data = {CMD_READ, 24'h0};
          csn_d   = 1'b0;
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (seg_end) begin
          sh_load = 1'b1;
          sh_len  = 6'd23;
          sh_data = {addr_q, 8'h00};
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (seg_end) begin
          sh_load = 1'b1;
          sh_len  = 6'd31;
          state_d = StData;
        end
      end
      StData: begin
        if (seg_end) begin
          csn_d   = 1'b1;
          ready_d = 1'b1;
          rdata_d = bswap32(sh_rx);
          gap_d   = '0;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StWakeCmd;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StWakeCmd;
      csn_q   <= 1'b1;
      ready_q <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      gap_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      csn_q   <= csn_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      gap_q   <= gap_d;
      wait_q  <= wait_d;
    end
  end

  assign flash_csn      = csn_q;
  assign ready_out      = ready_q;
  assign read_value_out = rdata_q;
  assign flash_io0_en   = 1'b1;

endmodule

// File: tb/tb_flash_reader.sv
// Directed bench for flash_reader: DIV=1 and DIV=3 instances share one SPI flash model.
module tb_flash_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] address_in = '0;
  logic        miso = 1'b0;
  logic        sel = 1'b0;

  logic        ready1, csn1, sclk1, mosi1, en1;
  logic [31:0] rv1;
  logic        ready3, csn3, sclk3, mosi3, en3;
  logic [31:0] rv3;

  flash_reader #(.DIV(1), .CSN_HIGH(4), .WAKE_CYCLES(48)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .address_in(address_in),
    .ready_out(ready1), .read_value_out(rv1), .flash_clk(sclk1), .flash_csn(csn1),
    .flash_io0_out(mosi1), .flash_io0_en(en1), .flash_io1_in(miso)
  );

  flash_reader #(.DIV(3), .CSN_HIGH(4), .WAKE_CYCLES(48)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .address_in(address_in),
    .ready_out(ready3), .read_value_out(rv3), .flash_clk(sclk3), .flash_csn(csn3),
    .flash_io0_out(mosi3), .flash_io0_en(en3), .flash_io1_in(miso)
  );

  always #5 clk = ~clk;

  logic        m_sclk, m_csn, m_mosi, m_ready;
  logic [31:0] m_rv;
  assign m_sclk  = sel ? sclk3  : sclk1;
  assign m_csn   = sel ? csn3   : csn1;
  assign m_mosi  = sel ? mosi3  : mosi1;
  assign m_ready = sel ? ready3 : ready1;
  assign m_rv    = sel ? rv3    : rv1;

  // Flash model: byte-addressed memory, READ returns bytes from the received address.
  logic [7:0]  mem [0:1023];
  int          mbits = 0;
  logic [31:0] msr = '0;
  logic [31:0] hdr = '0;
  logic [7:0]  wake_byte = '0;
  int          didx;
  logic [9:0]  daddr;
  logic [7:0]  dbyte;

  always @(posedge m_sclk) begin
    if (m_csn === 1'b0) begin
      msr = {msr[30:0], m_mosi};
      mbits++;
      if (mbits == 32) hdr = msr;
    end
  end

  always @(negedge m_sclk) begin
    if (m_csn === 1'b0 && mbits >= 32) begin
      didx  = mbits - 32;
      daddr = hdr[9:0] + 10'(didx / 8);
      dbyte = mem[daddr];
      miso  = dbyte[7 - (didx % 8)];
    end
  end

  always @(posedge m_csn) begin
    if (mbits == 8) wake_byte = msr[7:0];
    mbits = 0;
  end

  // Cycle monitor on the selected instance, sampled mid-cycle.
  int   cyc = 0, fall_cyc = 0, rise_cyc = 0, low_len = 0, highs = 0;
  int   ready_cnt = 0, ready_cyc = 0, rises = 0, last_rises = 0;
  int   last_sclk_rise = 0, sclk_period = 0;
  logic prev_csn = 1'b1, prev_sclk = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (m_csn === 1'b0 && prev_csn === 1'b1) begin
      fall_cyc = cyc; highs = cyc - rise_cyc; rises = 0;
    end
    if (m_csn === 1'b1 && prev_csn === 1'b0) begin
      rise_cyc = cyc; low_len = cyc - fall_cyc; last_rises = rises;
    end
    if (m_sclk === 1'b1 && prev_sclk === 1'b0) begin
      sclk_period = cyc - last_sclk_rise; last_sclk_rise = cyc; rises++;
    end
    if (m_ready === 1'b1) begin
      ready_cnt++; ready_cyc = cyc;
    end
    prev_csn  = m_csn;
    prev_sclk = m_sclk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (m_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_csn(input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (m_csn === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++; if (csn1 !== 1'b1) $display("FAIL reset_csn got %b want 1", csn1); else n_pass++;
    n_checks++; if (sclk1 !== 1'b0) $display("FAIL reset_sclk got %b want 0", sclk1); else n_pass++;
    n_checks++; if (mosi1 !== 1'b0) $display("FAIL reset_mosi got %b want 0", mosi1); else n_pass++;
    n_checks++; if (en1 !== 1'b1) $display("FAIL reset_io0_en got %b want 1", en1); else n_pass++;
    n_checks++; if (ready1 !== 1'b0) $display("FAIL reset_ready got %b want 0", ready1); else n_pass++;
    n_checks++;
    if (rv1 !== 32'h0) $display("FAIL reset_value got %h want 00000000", rv1); else n_pass++;
    n_checks++; if (csn3 !== 1'b1) $display("FAIL reset_csn_div3 got %b want 1", csn3); else n_pass++;
  endtask

  task automatic test_wake;
    bit ok1, ok2;
    int fall_before;
    wake_byte = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    wait_csn(1'b0, 50, ok1);
    wait_csn(1'b1, 100, ok2);
    @(posedge clk);
    n_checks++;
    if (!(ok1 && ok2)) $display("FAIL wake_timeout got %b%b want 11", ok1, ok2); else n_pass++;
    n_checks++; if (low_len !== 16) $display("FAIL wake_cs_low got %0d want 16", low_len); else n_pass++;
    n_checks++;
    if (wake_byte !== 8'hAB) $display("FAIL wake_cmd got %h want ab", wake_byte); else n_pass++;
    n_checks++;
    if (last_rises !== 8) $display("FAIL wake_edges got %0d want 8", last_rises); else n_pass++;
    fall_before = fall_cyc;
    repeat (100) @(posedge clk);
    n_checks++;
    if (fall_cyc !== fall_before) $display("FAIL wake_idle_cs got fall@%0d want none", fall_cyc);
    else n_pass++;
  endtask

  task automatic test_single_read;
    bit ok;
    logic [31:0] v;
    int rc;
    rc  = ready_cnt;
    hdr = '0;
    @(negedge clk);
    address_in = 32'h0000_0100;
    valid_in   = 1'b1;
    wait_ready(400, ok);
    v = m_rv;
    valid_in = 1'b0;
    @(posedge clk);
    n_checks++; if (!ok) $display("FAIL single_timeout got 0 want 1"); else n_pass++;
    n_checks++; if (v !== 32'h4433_2211) $display("FAIL single_value got %h want 44332211", v);
    else n_pass++;
    n_checks++; if (hdr !== 32'h0300_0100) $display("FAIL single_header got %h want 03000100", hdr);
    else n_pass++;
    n_checks++;
    if ((ready_cyc - fall_cyc + 1) !== 129)
      $display("FAIL single_latency got %0d want 129", ready_cyc - fall_cyc + 1);
    else n_pass++;
    n_checks++;
    if (rise_cyc !== ready_cyc) $display("FAIL single_cs_rise got %0d want %0d", rise_cyc, ready_cyc);
    else n_pass++;
    n_checks++; if (last_rises !== 64) $display("FAIL single_edges got %0d want 64", last_rises);
    else n_pass++;
    repeat (10) @(posedge clk);
    n_checks++; if (ready_cnt - rc !== 1) $display("FAIL single_pulses got %0d want 1", ready_cnt - rc);
    else n_pass++;
    n_checks++; if (rv1 !== 32'h4433_2211) $display("FAIL single_hold got %h want 44332211", rv1);
    else n_pass++;
  endtask

  task automatic test_unaligned;
    bit ok;
    logic [31:0] v;
    hdr = '0;
    @(negedge clk);
    address_in = 32'hFF00_0103;
    valid_in   = 1'b1;
    wait_ready(400, ok);
    v = m_rv;
    valid_in = 1'b0;
    @(posedge clk);
    n_checks++; if (!ok) $display("FAIL unaligned_timeout got 0 want 1"); else n_pass++;
    n_checks++; if (hdr !== 32'h0300_0100) $display("FAIL unaligned_header got %h want 03000100", hdr);
    else n_pass++;
    n_checks++; if (v !== 32'h4433_2211) $display("FAIL unaligned_value got %h want 44332211", v);
    else n_pass++;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_back_to_back;
    bit ok1, ok2;
    logic [31:0] v1, v2;
    int rc;
    rc = ready_cnt;
    @(negedge clk);
    address_in = 32'h0000_0000;
    valid_in   = 1'b1;
    wait_ready(400, ok1);
    v1 = m_rv;
    address_in = 32'h0000_0004;
    hdr = '0;
    wait_ready(400, ok2);
    v2 = m_rv;
    valid_in = 1'b0;
    @(posedge clk);
    n_checks++; if (!(ok1 && ok2)) $display("FAIL b2b_timeout got %b%b want 11", ok1, ok2); else n_pass++;
    n_checks++; if (v1 !== 32'hA3A2_A1A0) $display("FAIL b2b_first got %h want a3a2a1a0", v1);
    else n_pass++;
    n_checks++; if (v2 !== 32'hEFBE_ADDE) $display("FAIL b2b_second got %h want efbeadde", v2);
    else n_pass++;
    n_checks++; if (hdr !== 32'h0300_0004) $display("FAIL b2b_header got %h want 03000004", hdr);
    else n_pass++;
    n_checks++; if (highs !== 5) $display("FAIL b2b_cs_gap got %0d want 5", highs); else n_pass++;
    repeat (10) @(posedge clk);
    n_checks++; if (ready_cnt - rc !== 2) $display("FAIL b2b_pulses got %0d want 2", ready_cnt - rc);
    else n_pass++;
  endtask

  task automatic test_early_request;
    bit ok;
    logic [31:0] v;
    int rc;
    reset_n   = 1'b0;
    wake_byte = 8'h00;
    @(negedge clk);
    address_in = 32'h0000_0100;
    valid_in   = 1'b1;
    repeat (2) @(negedge clk);
    rc = ready_cnt;
    reset_n = 1'b1;
    wait_ready(600, ok);
    v = m_rv;
    valid_in = 1'b0;
    @(posedge clk);
    n_checks++; if (!ok) $display("FAIL early_timeout got 0 want 1"); else n_pass++;
    n_checks++; if (wake_byte !== 8'hAB) $display("FAIL early_wake got %h want ab", wake_byte);
    else n_pass++;
    n_checks++; if (highs !== 49) $display("FAIL early_cs_gap got %0d want 49", highs); else n_pass++;
    n_checks++; if (v !== 32'h4433_2211) $display("FAIL early_value got %h want 44332211", v);
    else n_pass++;
    n_checks++; if (ready_cnt - rc !== 1) $display("FAIL early_pulses got %0d want 1", ready_cnt - rc);
    else n_pass++;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_reset_mid_data;
    bit ok, ok1, ok2;
    int rc;
    rc = ready_cnt;
    @(negedge clk);
    address_in = 32'h0000_0100;
    valid_in   = 1'b1;
    wait_csn(1'b0, 50, ok);
    // Advance to the high half of bit 40.
    repeat (81) @(posedge clk);
    #2;
    n_checks++; if (!ok) $display("FAIL midreset_start got 0 want 1"); else n_pass++;
    n_checks++; if (m_sclk !== 1'b1) $display("FAIL midreset_phase got %b want 1", m_sclk); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if (m_csn !== 1'b1) $display("FAIL midreset_csn got %b want 1", m_csn); else n_pass++;
    n_checks++; if (m_sclk !== 1'b0) $display("FAIL midreset_sclk got %b want 0", m_sclk); else n_pass++;
    valid_in  = 1'b0;
    wake_byte = 8'h00;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    wait_csn(1'b0, 50, ok1);
    wait_csn(1'b1, 100, ok2);
    @(posedge clk);
    n_checks++; if (ready_cnt !== rc) $display("FAIL midreset_no_ready got %0d want %0d", ready_cnt, rc);
    else n_pass++;
    n_checks++;
    if (!(ok1 && ok2) || wake_byte !== 8'hAB || low_len !== 16)
      $display("FAIL midreset_rewake got %b%b %h %0d want 11 ab 16", ok1, ok2, wake_byte, low_len);
    else n_pass++;
    repeat (60) @(posedge clk);
  endtask

  task automatic test_div3;
    bit ok, ok1, ok2;
    logic [31:0] v;
    reset_n = 1'b0;
    valid_in = 1'b0;
    wake_byte = 8'h00;
    repeat (2) @(negedge clk);
    sel = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_csn(1'b0, 50, ok1);
    wait_csn(1'b1, 200, ok2);
    @(posedge clk);
    n_checks++; if (!(ok1 && ok2)) $display("FAIL div3_wake_timeout got %b%b want 11", ok1, ok2);
    else n_pass++;
    n_checks++; if (low_len !== 48) $display("FAIL div3_wake_low got %0d want 48", low_len); else n_pass++;
    n_checks++; if (wake_byte !== 8'hAB) $display("FAIL div3_wake_cmd got %h want ab", wake_byte);
    else n_pass++;
    hdr = '0;
    @(negedge clk);
    address_in = 32'h0000_0100;
    valid_in   = 1'b1;
    wait_ready(1000, ok);
    v = m_rv;
    valid_in = 1'b0;
    @(posedge clk);
    n_checks++; if (!ok) $display("FAIL div3_timeout got 0 want 1"); else n_pass++;
    n_checks++; if (v !== 32'h4433_2211) $display("FAIL div3_value got %h want 44332211", v);
    else n_pass++;
    n_checks++;
    if ((ready_cyc - fall_cyc + 1) !== 385)
      $display("FAIL div3_latency got %0d want 385", ready_cyc - fall_cyc + 1);
    else n_pass++;
    n_checks++; if (sclk_period !== 6) $display("FAIL div3_bit_period got %0d want 6", sclk_period);
    else n_pass++;
    n_checks++; if (last_rises !== 64) $display("FAIL div3_edges got %0d want 64", last_rises);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0]     = 8'hA0; mem[1]     = 8'hA1; mem[2]     = 8'hA2; mem[3]     = 8'hA3;
    mem[4]     = 8'hDE; mem[5]     = 8'hAD; mem[6]     = 8'hBE; mem[7]     = 8'hEF;
    mem[10'h100] = 8'h11; mem[10'h101] = 8'h22; mem[10'h102] = 8'h33; mem[10'h103] = 8'h44;
    test_reset;
    test_wake;
    test_single_read;
    test_unaligned;
    test_back_to_back;
    test_early_request;
    test_reset_mid_data;
    test_div3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
